// File: rtl/conv2_sched.sv
// conv2_sched: streams one feature map and the conv2 parameters into the 5x5 window buffer,
// then counts windows until the map is complete. Optional macro: CONV2_SCHED_PERF_EN (adds perf_cycles).
module conv2_sched #(
  parameter int WIDTH    = 12,
  parameter int HEIGHT   = 12,
  parameter int DATA_BIT = 12,
  parameter int ADDR_BIT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic                fm_rd_en,
  output logic [ADDR_BIT-1:0] fm_addr,
  input  logic [DATA_BIT-1:0] fm_rdata,
  output logic [4:0]          w_addr,
  input  logic [11:0]         w_rdata,
  output logic [1:0]          b_addr,
  input  logic [7:0]          b_rdata,
  output logic                buf_rst,
  output logic [DATA_BIT-1:0] buf_data,
  output logic [3:0]          buf_weight_1,
  output logic [3:0]          buf_weight_2,
  output logic [3:0]          buf_weight_3,
  output logic [7:0]          buf_bias,
  input  logic                buf_valid,
  output logic [7:0]          win_count,
  output logic                busy,
  output logic                done,
  output logic                err,
`ifdef CONV2_SCHED_PERF_EN
  output logic [15:0]         perf_cycles,
`endif
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [ADDR_BIT-1:0] LAST_ADDR  = ADDR_BIT'(WIDTH * HEIGHT - 1);
  localparam logic [7:0]          WIN_TARGET = 8'((WIDTH - 4) * (HEIGHT - 4));
  localparam int                  WD_BIT     = $clog2(2 * WIDTH + 1);
  localparam logic [WD_BIT-1:0]   WD_LAST    = WD_BIT'(2 * WIDTH - 1);

  state_t            state, next_state;
  logic [WD_BIT-1:0] wd_cnt;
  logic              start_acc;
  logic              win_inc;
  logic [7:0]        win_next;
  logic              wd_expire;

  // Handshake: start is a one-cycle request taken only in IDLE; abort overrides everything.
  assign start_acc = (state == S_IDLE) && start && !abort;
  assign win_inc   = ((state == S_STREAM) || (state == S_DRAIN)) && buf_valid && (win_count != 8'hFF);
  assign win_next  = win_count + 8'(win_inc);
  assign wd_expire = (state == S_DRAIN) && !buf_valid && (wd_cnt == WD_LAST);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start_acc) next_state = S_CLR;
      S_CLR:    next_state = S_STREAM;
      S_STREAM: if (fm_addr == LAST_ADDR) next_state = S_DRAIN;
      S_DRAIN:  if ((win_next >= WIN_TARGET) || wd_expire) next_state = S_DONE;
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
    if (abort) next_state = S_IDLE;
  end

  // RAM/ROM data pass straight through; the memories provide the one-cycle register.
  assign fm_rd_en     = (state == S_CLR) || (state == S_STREAM);
  assign buf_rst      = !((state == S_STREAM) || (state == S_DRAIN));
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign buf_data     = fm_rdata;
  assign buf_weight_1 = w_rdata[3:0];
  assign buf_weight_2 = w_rdata[7:4];
  assign buf_weight_3 = w_rdata[11:8];
  assign buf_bias     = b_rdata;
  assign dbg_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      fm_addr   <= '0;
      w_addr    <= '0;
      b_addr    <= '0;
      win_count <= '0;
      wd_cnt    <= '0;
      err       <= 1'b0;
    end else begin
      state <= next_state;

      if (state == S_IDLE) begin
        fm_addr <= '0;
        w_addr  <= '0;
        b_addr  <= '0;
      end else if ((state == S_CLR) || (state == S_STREAM)) begin
        if (fm_addr != LAST_ADDR) fm_addr <= fm_addr + 1'b1;
        if (w_addr != 5'd24)      w_addr  <= w_addr + 1'b1;
        if (b_addr != 2'd2)       b_addr  <= b_addr + 1'b1;
      end

      if (start_acc) win_count <= '0;
      else           win_count <= win_next;

      // Watchdog counts consecutive DRAIN cycles without a window.
      if ((state != S_DRAIN) || buf_valid) wd_cnt <= '0;
      else if (wd_cnt != WD_LAST)          wd_cnt <= wd_cnt + 1'b1;

      if (start_acc)               err <= 1'b0;
      else if (wd_expire && !abort) err <= 1'b1;
    end
  end

`ifdef CONV2_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                          perf_cycles <= '0;
    else if (start_acc)                                  perf_cycles <= '0;
    else if ((state != S_IDLE) && (perf_cycles != 16'hFFFF)) perf_cycles <= perf_cycles + 1'b1;
  end
`endif

endmodule
